// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional hardwired-zero
// register, optional write-to-read bypass and a per-register busy scoreboard
// that lets decode see which registers still have a write outstanding.
module regfile_mp #(
  parameter int W        = 32,
  parameter int DEPTH    = 32,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*W-1:0]  rd,
  output logic [NR-1:0]    rbusy,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [W-1:0]     wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [W-1:0]     wd1,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_a,
  output logic             conflict
);

  localparam int NA  = 1 << AW;
  localparam bit BYP = (BYPASS != 0);

  genvar gi;

  // Constant per-address mask: 1 where the address is a real, writable register.
  // Reads use the same mask, since non-writable addresses always read 0.
  logic [NA-1:0] wmask;
  generate
    for (gi = 0; gi < NA; gi++) begin : g_mask
      assign wmask[gi] = (gi < DEPTH) && !((ZERO_REG != 0) && (gi == 0));
    end
  endgenerate

  logic [W-1:0]     mem_reg  [DEPTH];
  logic [W-1:0]     mem_next [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic             conflict_reg;
  logic             conflict_next;

  // Per-register next state: port 1 beats port 0 on data, an issue beats a
  // write on the busy bit (a new producer was issued in the same cycle).
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic hit0, hit1, issue_hit, write_hit;
      assign hit0      = we0 && (wa0 == AW'(gi));
      assign hit1      = we1 && (wa1 == AW'(gi));
      assign issue_hit = iss_en && (iss_a == AW'(gi)) && wmask[gi];
      assign write_hit = hit0 || hit1;
      assign mem_next[gi]  = !wmask[gi] ? mem_reg[gi] :
                             hit1       ? wd1 :
                             hit0       ? wd0 : mem_reg[gi];
      assign busy_next[gi] = issue_hit ? 1'b1 :
                             write_hit ? 1'b0 : busy_reg[gi];
    end
  endgenerate

  // Both ports hitting the same writable register: port 0 data is lost.
  assign conflict_next = we0 && we1 && (wa0 == wa1) && wmask[wa0];

  // Register array, busy scoreboard and conflict flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      busy_reg     <= '0;
      conflict_reg <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= mem_next[i];
      busy_reg     <= busy_next;
      conflict_reg <= conflict_next;
    end
  end

  assign conflict = conflict_reg;

  // Read ports: combinational, with optional forwarding of in-flight writes.
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit0, hit1, issue_hit, write_hit;
      logic [W-1:0]  rd_p;
      logic          busy_p;

      assign a         = ra[gi*AW +: AW];
      assign hit0      = we0 && (wa0 == a);
      assign hit1      = we1 && (wa1 == a);
      assign issue_hit = iss_en && (iss_a == a);
      assign write_hit = hit0 || hit1;

      // Select forwarded or stored data and the (possibly forwarded) busy bit.
      always_comb begin
        rd_p   = '0;
        busy_p = 1'b0;
        if (rst_n && wmask[a]) begin
          if (BYP && hit1)      rd_p = wd1;
          else if (BYP && hit0) rd_p = wd0;
          else                  rd_p = mem_reg[a];
          busy_p = busy_reg[a] && !(BYP && write_hit && !issue_hit);
        end
      end

      assign rd[gi*W +: W] = rd_p;
      assign rbusy[gi]     = busy_p;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed vectors against a bypassing and a
// non-bypassing 32x32 instance, then a randomised run of a 64-bit, 16-deep,
// 4-read-port instance against a small reference model.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 32-bit / 32-deep / 2 read ports, shared by the bypass and no-bypass DUTs
  logic [9:0]  ra_ab;
  logic [63:0] rd_a, rd_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic        we0, we1, iss_en;
  logic [4:0]  wa0, wa1, iss_a;
  logic [31:0] wd0, wd1;
  logic        conflict_a, conflict_b;

  // 64-bit / 16-deep / 4 read ports
  logic [15:0]  ra_c;
  logic [255:0] rd_c;
  logic [3:0]   rbusy_c;
  logic         we0_c, we1_c, iss_en_c;
  logic [3:0]   wa0_c, wa1_c, iss_a_c;
  logic [63:0]  wd0_c, wd1_c;
  logic         conflict_c;

  regfile_mp #(.W(32), .DEPTH(32), .NR(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ra(ra_ab), .rd(rd_a), .rbusy(rbusy_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_a(iss_a), .conflict(conflict_a));

  regfile_mp #(.W(32), .DEPTH(32), .NR(2), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ra(ra_ab), .rd(rd_b), .rbusy(rbusy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_a(iss_a), .conflict(conflict_b));

  regfile_mp #(.W(64), .DEPTH(16), .NR(4), .ZERO_REG(1), .BYPASS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .ra(ra_c), .rd(rd_c), .rbusy(rbusy_c),
    .we0(we0_c), .wa0(wa0_c), .wd0(wd0_c), .we1(we1_c), .wa1(wa1_c), .wd1(wd1_c),
    .iss_en(iss_en_c), .iss_a(iss_a_c), .conflict(conflict_c));

  typedef struct {
    string       name;
    int          dut;   // 0 = bypass, 1 = no bypass, 2 = wide
    int          kind;  // 0 = rd, 1 = rbusy, 2 = conflict
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(string n, int d, int k, int p, logic [63:0] e);
    exp_t x;
    x.name = n; x.dut = d; x.kind = k; x.port = p; x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic er(string n, int d, int p, logic [63:0] e); push(n, d, 0, p, e); endtask
  task automatic eb(string n, int d, int p, logic e);        push(n, d, 1, p, {63'b0, e}); endtask
  task automatic ec(string n, int d, logic e);               push(n, d, 2, 0, {63'b0, e}); endtask

  function automatic logic [63:0] actual(int d, int k, int p);
    logic [63:0] v;
    v = '0;
    case (k)
      0: case (d)
           0: v = {32'b0, rd_a[p*32 +: 32]};
           1: v = {32'b0, rd_b[p*32 +: 32]};
           default: v = rd_c[p*64 +: 64];
         endcase
      1: case (d)
           0: v = {63'b0, rbusy_a[p]};
           1: v = {63'b0, rbusy_b[p]};
           default: v = {63'b0, rbusy_c[p]};
         endcase
      default: case (d)
           0: v = {63'b0, conflict_a};
           1: v = {63'b0, conflict_b};
           default: v = {63'b0, conflict_c};
         endcase
    endcase
    return v;
  endfunction

  // Monitor: the outputs are combinational/registered with no handshake, so
  // every queued expectation describes the outputs of the current half cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (sbq.size() > 0) begin
        exp_t        x;
        logic [63:0] act;
        x   = sbq.pop_front();
        act = actual(x.dut, x.kind, x.port);
        checks++;
        if (act !== x.exp) begin
          errors++;
          $display("FAIL %s: dut%0d kind%0d port%0d got %h expected %h",
                   x.name, x.dut, x.kind, x.port, act, x.exp);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(string label);
    @(negedge clk);
    #1;
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    $display("[%0t] step %s", $time, label);
  endtask

  task automatic set_ra(logic [4:0] p0, logic [4:0] p1);
    ra_ab = {p1, p0};
  endtask

  // Reference model for the wide instance
  logic [63:0] mc [16];
  logic [15:0] bc;
  logic        cc;

  initial begin
    rst_n = 1'b0;
    ra_ab = '0; we0 = 0; we1 = 0; iss_en = 0; wa0 = '0; wa1 = '0; iss_a = '0; wd0 = '0; wd1 = '0;
    ra_c = '0; we0_c = 0; we1_c = 0; iss_en_c = 0; wa0_c = '0; wa1_c = '0; iss_a_c = '0;
    wd0_c = '0; wd1_c = '0;
    for (int i = 0; i < 16; i++) mc[i] = '0;
    bc = '0; cc = 1'b0;

    // Reset
    step("reset held"); set_ra(5, 5);
    er("rst rd", 0, 0, 0); er("rst rd", 1, 0, 0); eb("rst busy", 0, 0, 0); ec("rst conflict", 0, 0);
    step("release, write r5 via port1"); rst_n = 1'b1;
    we1 = 1; wa1 = 5; wd1 = 32'hDEADBEEF;
    er("bypass r5", 0, 0, 32'hDEADBEEF); er("nobypass r5 pre", 1, 0, 0);
    step("r5 stored, issue r5"); iss_en = 1; iss_a = 5;
    er("r5 stored", 0, 0, 32'hDEADBEEF); er("r5 stored", 1, 0, 32'hDEADBEEF); eb("r5 busy pre", 0, 0, 0);
    step("r5 busy");
    eb("r5 busy", 0, 0, 1); eb("r5 busy", 1, 1, 1);
    step("reset pulse mid-cycle"); rst_n = 1'b0;
    er("rst r5", 0, 0, 0); er("rst r5", 1, 1, 0); eb("rst r5 busy", 0, 0, 0); eb("rst r5 busy", 1, 1, 0);
    step("reset released"); rst_n = 1'b1;
    er("r5 after rst", 0, 0, 0); eb("r5 busy after rst", 0, 0, 0);

    // Zero register
    step("write+issue r0"); set_ra(0, 0);
    we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; iss_en = 1; iss_a = 0;
    er("r0 pre", 0, 0, 0); er("r0 pre", 1, 0, 0); eb("r0 busy pre", 0, 0, 0);
    step("r0 after edge");
    er("r0 post", 0, 0, 0); er("r0 post", 1, 1, 0); eb("r0 busy", 0, 0, 0); eb("r0 busy", 1, 0, 0);
    ec("r0 no conflict", 0, 0);

    // Conflict
    step("both ports write r7"); set_ra(7, 7);
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22;
    er("conflict bypass", 0, 0, 32'h22); er("conflict nobypass pre", 1, 0, 0); ec("conflict pre", 0, 0);
    step("conflict flagged");
    er("r7", 0, 0, 32'h22); er("r7", 1, 1, 32'h22); ec("conflict", 0, 1); ec("conflict", 1, 1);
    step("conflict cleared");
    ec("conflict one cycle", 0, 0); ec("conflict one cycle", 1, 0);
    step("both ports write r0"); set_ra(0, 7);
    we0 = 1; wa0 = 0; wd0 = 32'h1; we1 = 1; wa1 = 0; wd1 = 32'h2;
    er("r0 both", 0, 0, 0);
    step("no conflict on r0");
    ec("r0 conflict", 0, 0); er("r7 kept", 0, 1, 32'h22);

    // Bypass
    step("port0 write r3"); set_ra(3, 3);
    we0 = 1; wa0 = 3; wd0 = 32'h1111;
    er("bypass p0", 0, 0, 32'h1111); er("nobypass p0", 1, 0, 0);
    step("port1 write r3");
    we1 = 1; wa1 = 3; wd1 = 32'hABCD;
    er("bypass p1", 0, 0, 32'hABCD); er("bypass p1 rd1", 0, 1, 32'hABCD); er("nobypass old", 1, 0, 32'h1111);
    step("port0 write r3 again");
    we0 = 1; wa0 = 3; wd0 = 32'h5555;
    er("bypass p0 rd1", 0, 1, 32'h5555); er("nobypass old2", 1, 1, 32'hABCD);
    step("r3 stored");
    er("r3 stored", 0, 0, 32'h5555); er("r3 stored", 1, 0, 32'h5555);
    step("port1 write r4, read r3/r4"); set_ra(3, 4);
    we1 = 1; wa1 = 4; wd1 = 32'h9999;
    er("no bypass other", 0, 0, 32'h5555); er("bypass r4", 0, 1, 32'h9999); er("nobypass r4", 1, 1, 0);

    // Scoreboard
    step("issue r9"); set_ra(9, 9);
    iss_en = 1; iss_a = 9;
    eb("r9 busy pre", 0, 0, 0); eb("r9 busy pre", 1, 0, 0);
    step("r9 busy");
    eb("r9 busy", 0, 0, 1); eb("r9 busy", 1, 1, 1);
    step("write r9 clears");
    we0 = 1; wa0 = 9; wd0 = 32'h77;
    eb("r9 clear fwd", 0, 0, 0); eb("r9 clear nofwd", 1, 0, 1); er("r9 fwd", 0, 1, 32'h77);
    step("r9 cleared");
    eb("r9 cleared", 0, 0, 0); eb("r9 cleared", 1, 0, 0); er("r9", 1, 0, 32'h77);
    step("issue r9 again");
    iss_en = 1; iss_a = 9;
    eb("r9 idle", 0, 0, 0);
    step("issue+write r9 same edge");
    iss_en = 1; iss_a = 9; we1 = 1; wa1 = 9; wd1 = 32'h88;
    eb("set beats clear fwd", 0, 0, 1); eb("set beats clear", 1, 0, 1); er("r9 fwd2", 0, 0, 32'h88);
    step("r9 still busy");
    eb("r9 still busy", 0, 0, 1); eb("r9 still busy", 1, 1, 1); er("r9 stored2", 1, 0, 32'h88);
    step("both ports write r9");
    we0 = 1; wa0 = 9; wd0 = 32'h66; we1 = 1; wa1 = 9; wd1 = 32'h99;
    eb("r9 clear2 fwd", 0, 0, 0); eb("r9 clear2 nofwd", 1, 0, 1);
    step("r9 idle, conflict");
    eb("r9 idle2", 0, 0, 0); eb("r9 idle2", 1, 0, 0); ec("conflict r9", 0, 1); er("r9 p1 wins", 0, 0, 32'h99);

    // Wide instance, randomised against the reference model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      #1;
      we0_c    = 1'($urandom_range(0, 1));
      we1_c    = 1'($urandom_range(0, 1));
      iss_en_c = 1'($urandom_range(0, 1));
      wa0_c    = 4'($urandom_range(0, 15));
      wa1_c    = 4'($urandom_range(0, 15));
      iss_a_c  = 4'($urandom_range(0, 15));
      wd0_c    = {$urandom, $urandom};
      wd1_c    = {$urandom, $urandom};
      for (int p = 0; p < 4; p++) ra_c[p*4 +: 4] = 4'($urandom_range(0, 15));
      if (cyc % 1000 == 0) $display("[%0t] random batch %0d", $time, cyc / 1000);

      ec("rand conflict", 2, cc);
      for (int p = 0; p < 4; p++) begin
        logic [3:0]  a;
        logic [63:0] e;
        logic        b, clr, setb;
        a = ra_c[p*4 +: 4];
        e = '0; b = 1'b0;
        if (a != 0) begin
          e = mc[a];
          if (we0_c && wa0_c == a) e = wd0_c;
          if (we1_c && wa1_c == a) e = wd1_c;
          clr  = (we0_c && wa0_c == a) || (we1_c && wa1_c == a);
          setb = iss_en_c && iss_a_c == a;
          b    = (clr && !setb) ? 1'b0 : bc[a];
        end
        er("rand rd", 2, p, e);
        eb("rand busy", 2, p, b);
      end

      cc = we0_c && we1_c && (wa0_c == wa1_c) && (wa0_c != 0);
      for (int r = 1; r < 16; r++) begin
        logic clr, setb;
        clr  = (we0_c && wa0_c == 4'(r)) || (we1_c && wa1_c == 4'(r));
        setb = iss_en_c && iss_a_c == 4'(r);
        if (we1_c && wa1_c == 4'(r))      mc[r] = wd1_c;
        else if (we0_c && wa0_c == 4'(r)) mc[r] = wd0_c;
        if (setb)     bc[r] = 1'b1;
        else if (clr) bc[r] = 1'b0;
      end
    end

    @(negedge clk); #1;
    we0_c = 0; we1_c = 0; iss_en_c = 0;
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
